// File: rtl/fpga_cfg_pkg.sv
// Shared fixed-point configuration for the path-simulation datapath.
package fpga_cfg_pkg;
    localparam int FP_WIDTH = 16;
endpackage

// File: rtl/fx_exp_arbiter.sv
// Round-robin share of one exp engine among N_REQ lanes with an in-order tag FIFO; 0-cycle request/response paths.
// Backpressure: issue stalls on eng_ready_out or a full tag FIFO; results stall on the owning lane's rsp_ready.
module fx_exp_arbiter #(
    parameter int N_REQ     = 4,
    parameter int WIDTH     = fpga_cfg_pkg::FP_WIDTH,
    parameter int TAG_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [N_REQ-1:0]                req_valid,
    output logic [N_REQ-1:0]                req_ready,
    input  logic [N_REQ-1:0][WIDTH-1:0]     req_a,
    output logic [N_REQ-1:0]                rsp_valid,
    input  logic [N_REQ-1:0]                rsp_ready,
    output logic [WIDTH-1:0]                rsp_result,
    output logic                            eng_valid_in,
    input  logic                            eng_ready_out,
    output logic [WIDTH-1:0]                eng_a,
    input  logic                            eng_valid_out,
    output logic                            eng_ready_in,
    input  logic [WIDTH-1:0]                eng_result,
    output logic [$clog2(TAG_DEPTH):0]      outstanding,
    output logic                            err_orphan
);
    localparam int IDW = $clog2(N_REQ);
    localparam int PW  = $clog2(TAG_DEPTH);
    localparam int CW  = PW + 1;

    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0] lock_idx_q, lock_idx_d;
    logic           lock_vld_q, lock_vld_d;
    logic [IDW-1:0] tag_mem_q [TAG_DEPTH];
    logic [IDW-1:0] tag_mem_d [TAG_DEPTH];
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           err_orphan_q, err_orphan_d;

    logic [IDW-1:0] grant;
    logic [IDW-1:0] head;
    logic           found, any_vld, tag_full, fifo_empty, push, pop;

    // A stalled grant stays locked so eng_a cannot change under a pending handshake.
    always_comb begin
        grant = rr_ptr_q;
        found = 1'b0;
        if (lock_vld_q && req_valid[lock_idx_q]) begin
            grant = lock_idx_q;
        end else begin
            for (int k = 0; k < N_REQ; k++) begin
                if (!found && req_valid[(int'(rr_ptr_q) + k) % N_REQ]) begin
                    grant = IDW'((int'(rr_ptr_q) + k) % N_REQ);
                    found = 1'b1;
                end
            end
        end
    end

    assign any_vld      = |req_valid;
    assign fifo_empty   = (count_q == '0);
    assign tag_full     = (count_q == CW'(TAG_DEPTH));
    assign head         = tag_mem_q[rd_ptr_q];
    assign eng_valid_in = any_vld && !tag_full;
    assign eng_a        = req_a[grant];
    assign push         = eng_valid_in && eng_ready_out;
    // Orphan results are drained unconditionally so the engine never wedges.
    assign eng_ready_in = fifo_empty ? 1'b1 : rsp_ready[head];
    assign pop          = eng_valid_out && eng_ready_in && !fifo_empty;
    assign rsp_result   = eng_result;
    assign outstanding  = count_q;
    assign err_orphan   = err_orphan_q;

    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        for (int i = 0; i < N_REQ; i++) begin
            req_ready[i] = (IDW'(i) == grant) && any_vld && eng_ready_out && !tag_full;
            rsp_valid[i] = (IDW'(i) == head) && eng_valid_out && !fifo_empty;
        end
    end

    always_comb begin
        rr_ptr_d     = rr_ptr_q;
        lock_idx_d   = lock_idx_q;
        lock_vld_d   = lock_vld_q;
        tag_mem_d    = tag_mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        err_orphan_d = err_orphan_q || (eng_valid_out && fifo_empty);
        if (push) begin
            rr_ptr_d             = (grant == IDW'(N_REQ - 1)) ? '0 : grant + IDW'(1);
            lock_vld_d           = 1'b0;
            tag_mem_d[wr_ptr_q]  = grant;
            wr_ptr_d             = wr_ptr_q + PW'(1);
        end else if (eng_valid_in) begin
            lock_vld_d = 1'b1;
            lock_idx_d = grant;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q     <= '0;
            lock_idx_q   <= '0;
            lock_vld_q   <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            err_orphan_q <= 1'b0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            lock_idx_q   <= lock_idx_d;
            lock_vld_q   <= lock_vld_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            err_orphan_q <= err_orphan_d;
        end
    end

    always_ff @(posedge clk) begin
        tag_mem_q <= tag_mem_d;
    end
endmodule

// File: tb/tb_fx_exp_arbiter.sv
// Directed bench for fx_exp_arbiter with a 1-cycle, result = a+1 engine model.
module tb_fx_exp_arbiter;
    localparam int W = fpga_cfg_pkg::FP_WIDTH;

    logic               clk;
    logic               rst_n;
    logic [3:0]         req_valid;
    logic [3:0]         req_ready;
    logic [3:0][W-1:0]  req_a;
    logic [3:0]         rsp_valid;
    logic [3:0]         rsp_ready;
    logic [W-1:0]       rsp_result;
    logic               eng_valid_in;
    logic               eng_ready_out;
    logic [W-1:0]       eng_a;
    logic               eng_valid_out;
    logic               eng_ready_in;
    logic [W-1:0]       eng_result;
    logic [2:0]         outstanding;
    logic               err_orphan;

    logic               inj;
    logic [W-1:0]       inj_val;
    logic [W-1:0]       eq [8];
    logic [2:0]         ewp, erp;
    int                 rcnt [4] = '{0, 0, 0, 0};
    int                 base [4];
    int                 checks = 0;
    int                 errors = 0;

    fx_exp_arbiter #(.N_REQ(4), .WIDTH(W), .TAG_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .eng_valid_in(eng_valid_in), .eng_ready_out(eng_ready_out), .eng_a(eng_a),
        .eng_valid_out(eng_valid_out), .eng_ready_in(eng_ready_in), .eng_result(eng_result),
        .outstanding(outstanding), .err_orphan(err_orphan)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Engine model: in-order result queue, each result visible the cycle after issue.
    assign eng_valid_out = inj || (ewp != erp);
    assign eng_result    = inj ? inj_val : eq[erp];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ewp <= '0;
            erp <= '0;
        end else begin
            if (eng_valid_in && eng_ready_out) ewp <= ewp + 3'd1;
            if (!inj && eng_valid_out && eng_ready_in) erp <= erp + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (eng_valid_in && eng_ready_out) eq[ewp] <= eng_a + W'(1);
    end

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (rsp_valid[i] && rsp_ready[i]) rcnt[i] <= rcnt[i] + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1; req_valid = '0; req_a = '0; rsp_ready = 4'hF;
        eng_ready_out = 1'b1; inj = 1'b0; inj_val = '0;
        #1 rst_n = 1'b0;
        #2;
        check("rst_outstanding", 32'(outstanding), 0);
        check("rst_err_orphan", 32'(err_orphan), 0);
        check("rst_req_ready", 32'(req_ready), 0);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_eng_valid_in", 32'(eng_valid_in), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single lane
        @(negedge clk);
        req_valid = 4'b0100; req_a[2] = 16'h0100;
        #1;
        check("t1_req_ready", 32'(req_ready), 32'b0100);
        check("t1_eng_a", 32'(eng_a), 32'h0100);
        check("t1_out_pre", 32'(outstanding), 0);
        @(negedge clk);
        req_valid = '0;
        #1;
        check("t1_rsp_valid", 32'(rsp_valid), 32'b0100);
        check("t1_rsp_result", 32'(rsp_result), 32'h0101);
        check("t1_out_mid", 32'(outstanding), 1);
        @(negedge clk);
        #1;
        check("t1_out_post", 32'(outstanding), 0);
        check("t1_rsp_idle", 32'(rsp_valid), 0);

        // Round-robin, all four lanes valid
        pulse_reset();
        for (int i = 0; i < 4; i++) begin
            base[i] = rcnt[i];
            req_a[i] = W'(16'h0200 + i);
        end
        req_valid = 4'hF;
        for (int c = 0; c < 8; c++) begin
            #1;
            check("rr_eng_a", 32'(eng_a), 32'h0200 + 32'(c % 4));
            check("rr_req_ready", 32'(req_ready), 32'(1) << (c % 4));
            if (c > 0) begin
                check("rr_rsp_valid", 32'(rsp_valid), 32'(1) << ((c - 1) % 4));
                check("rr_rsp_result", 32'(rsp_result), 32'h0201 + 32'((c - 1) % 4));
            end
            @(negedge clk);
        end
        req_valid = '0;
        #1;
        check("rr_last_valid", 32'(rsp_valid), 32'b1000);
        check("rr_last_result", 32'(rsp_result), 32'h0204);
        @(negedge clk);
        #1;
        for (int i = 0; i < 4; i++) check("rr_lane_count", 32'(rcnt[i] - base[i]), 2);

        // Stall and grant lock
        req_a[3] = 16'h0300; req_a[0] = 16'h0050;
        req_valid = 4'b1000; eng_ready_out = 1'b0;
        #1;
        check("lk_valid_in", 32'(eng_valid_in), 1);
        check("lk_eng_a0", 32'(eng_a), 32'h0300);
        check("lk_ready0", 32'(req_ready), 0);
        @(negedge clk);
        req_valid = 4'b1001;
        #1;
        check("lk_eng_a1", 32'(eng_a), 32'h0300);
        check("lk_ready1", 32'(req_ready), 0);
        @(negedge clk);
        #1;
        check("lk_eng_a2", 32'(eng_a), 32'h0300);
        @(negedge clk);
        eng_ready_out = 1'b1;
        #1;
        check("lk_ready3", 32'(req_ready), 32'b1000);
        check("lk_eng_a3", 32'(eng_a), 32'h0300);
        @(negedge clk);
        req_valid = 4'b0001;
        #1;
        check("lk_eng_a_l0", 32'(eng_a), 32'h0050);
        check("lk_ready_l0", 32'(req_ready), 32'b0001);
        check("lk_rsp3_valid", 32'(rsp_valid), 32'b1000);
        check("lk_rsp3_result", 32'(rsp_result), 32'h0301);
        @(negedge clk);
        req_valid = '0;
        #1;
        check("lk_rsp0_valid", 32'(rsp_valid), 32'b0001);
        check("lk_rsp0_result", 32'(rsp_result), 32'h0051);
        @(negedge clk);
        #1;
        check("lk_out_idle", 32'(outstanding), 0);

        // Full tag FIFO: issue order from rr_ptr=1 is 1,2,3,0
        rsp_ready = '0;
        for (int i = 0; i < 4; i++) req_a[i] = W'(16'h0400 + i);
        req_valid = 4'hF;
        for (int k = 0; k < 6; k++) begin
            #1;
            check("ff_outstanding", 32'(outstanding), (k < 4) ? 32'(k) : 32'd4);
            if (k < 4) begin
                check("ff_valid_in", 32'(eng_valid_in), 1);
                check("ff_eng_a", 32'(eng_a), 32'h0400 + 32'((1 + k) % 4));
            end else begin
                check("ff_blocked", 32'(eng_valid_in), 0);
                check("ff_req_ready", 32'(req_ready), 0);
            end
            @(negedge clk);
        end
        #1;
        check("ff_hold_valid", 32'(rsp_valid), 32'b0010);
        check("ff_hold_ready_in", 32'(eng_ready_in), 0);
        rsp_ready = 4'hF;
        #1;
        check("ff_d0_valid", 32'(rsp_valid), 32'b0010);
        check("ff_d0_result", 32'(rsp_result), 32'h0402);
        check("ff_d0_no_push", 32'(eng_valid_in), 0);
        @(negedge clk);
        #1;
        check("ff_d1_out", 32'(outstanding), 3);
        check("ff_resume", 32'(eng_valid_in), 1);
        check("ff_resume_a", 32'(eng_a), 32'h0401);
        check("ff_d1_valid", 32'(rsp_valid), 32'b0100);
        check("ff_d1_result", 32'(rsp_result), 32'h0403);
        @(negedge clk);
        req_valid = '0;
        #1;
        check("ff_d2_out", 32'(outstanding), 3);
        check("ff_d2_valid", 32'(rsp_valid), 32'b1000);
        check("ff_d2_result", 32'(rsp_result), 32'h0404);
        @(negedge clk);
        #1;
        check("ff_d3_out", 32'(outstanding), 2);
        check("ff_d3_valid", 32'(rsp_valid), 32'b0001);
        check("ff_d3_result", 32'(rsp_result), 32'h0401);
        @(negedge clk);
        #1;
        check("ff_d4_out", 32'(outstanding), 1);
        check("ff_d4_valid", 32'(rsp_valid), 32'b0010);
        check("ff_d4_result", 32'(rsp_result), 32'h0402);
        @(negedge clk);
        #1;
        check("ff_empty", 32'(outstanding), 0);
        check("ff_rsp_idle", 32'(rsp_valid), 0);

        // Orphan result
        inj = 1'b1; inj_val = 16'h0777;
        #1;
        check("or_ready_in", 32'(eng_ready_in), 1);
        check("or_no_rsp", 32'(rsp_valid), 0);
        check("or_not_yet", 32'(err_orphan), 0);
        @(negedge clk);
        inj = 1'b0;
        #1;
        check("or_set", 32'(err_orphan), 1);
        repeat (3) @(negedge clk);
        #1;
        check("or_sticky", 32'(err_orphan), 1);

        // Async reset with three transactions outstanding
        rsp_ready = '0;
        for (int i = 0; i < 4; i++) req_a[i] = W'(16'h0600 + i);
        req_valid = 4'hF;
        repeat (3) @(negedge clk);
        req_valid = '0;
        #1;
        check("ar_out_pre", 32'(outstanding), 3);
        #2 rst_n = 1'b0;
        #1;
        check("ar_outstanding", 32'(outstanding), 0);
        check("ar_err_orphan", 32'(err_orphan), 0);
        check("ar_rsp_valid", 32'(rsp_valid), 0);
        check("ar_eng_valid_in", 32'(eng_valid_in), 0);
        check("ar_req_ready", 32'(req_ready), 0);
        check("ar_eng_ready_in", 32'(eng_ready_in), 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
